bcd_display_sequencer: RTL and testbench

//  Sequences a 2-digit BCD value (00-99) onto the two 7-seg displays HEX1/HEX0.
//  - Rate-divided up/down counter with start/pause/stop/load control.
//  - Flashes the display when the count reaches a terminal value.
//  - Sits between board controls (KEY/SW) and the displays; the BCD-to-7-seg decode is internal.

---
 rtl/bcd_display_sequencer.sv | 175 +++++++++++++++++
 tb/tb_bcd_display_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_sequencer.sv
// Two-digit BCD up/down counter with start/pause/stop/load control, terminal-value
// flashing, and an internal BCD-to-7-segment decode for the HEX1/HEX0 displays.
module bcd_display_sequencer #(
  parameter int unsigned DIV       = 50_000_000,
  parameter int unsigned FLASH_DIV = 25_000_000,
  parameter logic [7:0]  TERM      = 8'h99
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Stop,
  input  logic       Load,
  input  logic       Up,
  input  logic [7:0] LoadValue,
  output logic [7:0] Count,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic       Done,
  output logic       Running
);

  localparam int unsigned TICK_W  = $clog2(DIV);
  localparam int unsigned FLASH_W = $clog2(FLASH_DIV);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t               state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [FLASH_W-1:0]   flash_cnt;
  logic                 blank;
  logic [7:0]           step;
  logic [7:0]           terminal;
  logic [7:0]           load_clamped;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = v[7:4];
    o = v[3:0];
    if (o == 4'd9) begin
      o = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = v[7:4];
    o = v[3:0];
    if (o == 4'd0) begin
      o = 4'd9;
      t = (t == 4'd0) ? 4'd9 : t - 4'd1;
    end else begin
      o = o - 4'd1;
    end
    return {t, o};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign step         = Up ? bcd_inc(Count) : bcd_dec(Count);
  assign terminal     = Up ? TERM : 8'h00;
  assign load_clamped = {(LoadValue[7:4] > 4'd9) ? 4'd9 : LoadValue[7:4],
                         (LoadValue[3:0] > 4'd9) ? 4'd9 : LoadValue[3:0]};

  // Decode follows the registered Count directly, so HEX is never a cycle behind.
  assign HEX1 = blank ? 7'b1111111 : seg7(Count[7:4]);
  assign HEX0 = blank ? 7'b1111111 : seg7(Count[3:0]);

  // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state     <= S_IDLE;
      Count     <= 8'h00;
      tick_cnt  <= '0;
      flash_cnt <= '0;
      blank     <= 1'b0;
      Done      <= 1'b0;
      Running   <= 1'b0;
    end else if (Stop) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      flash_cnt <= '0;
      blank     <= 1'b0;
      Done      <= 1'b0;
      Running   <= 1'b0;
    end else if (Load && state != S_RUN) begin
      Count <= load_clamped;
      if (state == S_DONE) begin
        state     <= S_IDLE;
        Done      <= 1'b0;
        flash_cnt <= '0;
        blank     <= 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (Count == terminal) begin
              state     <= S_DONE;
              Done      <= 1'b1;
              flash_cnt <= '0;
              blank     <= 1'b0;
            end else begin
              state    <= S_RUN;
              Running  <= 1'b1;
              tick_cnt <= '0;
            end
          end
        end
        S_RUN: begin
          // Pause freezes tick_cnt so a later resume keeps the partial tick period.
          if (Pause) begin
            state   <= S_PAUSE;
            Running <= 1'b0;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            Count    <= step;
            if (step == terminal) begin
              state     <= S_DONE;
              Running   <= 1'b0;
              Done      <= 1'b1;
              flash_cnt <= '0;
              blank     <= 1'b0;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_PAUSE: begin
          if (Start) begin
            state   <= S_RUN;
            Running <= 1'b1;
          end
        end
        S_DONE: begin
          if (Start) begin
            state     <= S_IDLE;
            Done      <= 1'b0;
            flash_cnt <= '0;
            blank     <= 1'b0;
          end else if (flash_cnt == FLASH_LAST) begin
            flash_cnt <= '0;
            blank     <= ~blank;
          end else begin
            flash_cnt <= flash_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Scoreboard bench: a decimal-arithmetic reference model predicts every post-edge
// output; a separate monitor pops predictions and compares them against the DUT.
module tb_bcd_display_sequencer;

  localparam int unsigned DIV       = 4;
  localparam int unsigned FLASH_DIV = 3;
  localparam logic [7:0]  TERM      = 8'h12;
  localparam int          TERM_DEC  = 12;

  logic       clk;
  logic       reset, start, pause, stop, load, up;
  logic [7:0] load_value;
  logic [7:0] count;
  logic [6:0] hex1, hex0;
  logic       done, running;

  bcd_display_sequencer #(.DIV(DIV), .FLASH_DIV(FLASH_DIV), .TERM(TERM)) dut (
    .CLOCK_50 (clk),
    .Reset    (reset),
    .Start    (start),
    .Pause    (pause),
    .Stop     (stop),
    .Load     (load),
    .Up       (up),
    .LoadValue(load_value),
    .Count    (count),
    .HEX1     (hex1),
    .HEX0     (hex0),
    .Done     (done),
    .Running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [7:0] cnt;
    logic       done;
    logic       run;
    logic [6:0] h1;
    logic [6:0] h0;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;

  exp_t  sb[$];
  int    edge_cnt = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  logic  up_lvl   = 1'b1;

  // Reference model: count held as a plain decimal integer 0..99.
  mode_t m_mode  = M_IDLE;
  int    m_cnt   = 0;
  int    m_phase = 0;
  int    m_fph   = 0;
  bit    m_blank = 1'b0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_dec(input logic [7:0] lv);
    int t;
    int o;
    t = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
    o = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
    return t * 10 + o;
  endfunction

  task automatic enter_done();
    m_mode  = M_DONE;
    m_fph   = 0;
    m_blank = 1'b0;
  endtask

  task automatic model_step(input bit rs, st, pa, sp, ld, u, input logic [7:0] lv);
    int term_now;
    term_now = u ? TERM_DEC : 0;
    if (rs) begin
      m_mode = M_IDLE; m_cnt = 0; m_phase = 0; m_fph = 0; m_blank = 1'b0;
    end else if (sp) begin
      m_mode = M_IDLE; m_phase = 0; m_fph = 0; m_blank = 1'b0;
    end else if (ld && m_mode != M_RUN) begin
      m_cnt = clamp_dec(lv);
      if (m_mode == M_DONE) begin
        m_mode = M_IDLE; m_fph = 0; m_blank = 1'b0;
      end
    end else begin
      case (m_mode)
        M_IDLE: if (st) begin
          if (m_cnt == term_now) enter_done();
          else begin m_mode = M_RUN; m_phase = 0; end
        end
        M_RUN: if (pa) m_mode = M_PAUSE;
        else begin
          m_phase = (m_phase + 1) % DIV;
          if (m_phase == 0) begin
            m_cnt = u ? (m_cnt + 1) % 100 : (m_cnt + 99) % 100;
            if (m_cnt == term_now) enter_done();
          end
        end
        M_PAUSE: if (st) m_mode = M_RUN;
        M_DONE: if (st) begin
          m_mode = M_IDLE; m_fph = 0; m_blank = 1'b0;
        end else begin
          m_fph = (m_fph + 1) % FLASH_DIV;
          if (m_fph == 0) m_blank = ~m_blank;
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs at the falling edge and predict the state after the next rise.
  task automatic cyc(input bit rs, st, pa, sp, ld, input logic [7:0] lv);
    exp_t e;
    @(negedge clk);
    reset = rs; start = st; pause = pa; stop = sp; load = ld; up = up_lvl; load_value = lv;
    model_step(rs, st, pa, sp, ld, up_lvl, lv);
    e.tag  = edge_cnt + 1;
    e.cnt  = to_bcd(m_cnt);
    e.done = (m_mode == M_DONE);
    e.run  = (m_mode == M_RUN);
    e.h1   = m_blank ? 7'b1111111 : seg_tab[m_cnt / 10];
    e.h0   = m_blank ? 7'b1111111 : seg_tab[m_cnt % 10];
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic check(input string name, input int tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s edge %0d: got %h expected %h", name, tag, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
        e = sb.pop_front();
        check("stale_entry", e.tag, 8'(edge_cnt - e.tag), 8'd0);
        check("count",   e.tag, count,       e.cnt);
        check("done",    e.tag, 8'(done),    8'(e.done));
        check("running", e.tag, 8'(running), 8'(e.run));
        check("hex1",    e.tag, 8'(hex1),    8'(e.h1));
        check("hex0",    e.tag, 8'(hex0),    8'(e.h0));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; load = 1'b0;
    up = 1'b1; load_value = 8'h00;

    // Reset, then a plain up-count run
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    idle(2);
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle(10);

    // Carry 09 -> 10, then borrow 10 -> 09
    cyc(0, 0, 0, 1, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h09);
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle(5);
    cyc(0, 0, 0, 1, 0, 8'h00);
    up_lvl = 1'b0;
    cyc(0, 0, 0, 0, 1, 8'h10);
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle(5);

    // Terminal reached from 11 counting up, then flashing
    cyc(0, 0, 0, 1, 0, 8'h00);
    up_lvl = 1'b1;
    cyc(0, 0, 0, 0, 1, 8'h11);
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle(14);
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle(2);

    // Clamp FA -> 99, wrap 99 -> 00 upward, then 00 -> 99 downward
    cyc(0, 0, 0, 0, 1, 8'hFA);
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle(5);
    cyc(0, 0, 0, 1, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00);
    up_lvl = 1'b0;
    idle(5);

    // Pause mid-period, resume, then Stop+Start in the same cycle
    cyc(0, 0, 0, 1, 0, 8'h00);
    up_lvl = 1'b1;
    cyc(0, 0, 0, 0, 1, 8'h30);
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle(2);
    cyc(0, 0, 1, 0, 0, 8'h00);
    idle(10);
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle(3);
    cyc(0, 1, 0, 1, 0, 8'h00);
    idle(3);

    // Reset while blanked in DONE
    cyc(0, 0, 0, 0, 1, 8'h11);
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle(7);
    cyc(1, 0, 0, 0, 0, 8'h00);
    idle(2);

    // Randomized control traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) up_lvl = ~up_lvl;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 24) == 0, 8'($urandom));
    end

    idle(1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
